// File: rtl/con_pkg.sv
// Shared definitions for the branch-condition unit: condition codes, FSM states, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package con_pkg;

  // Condition codes; 0-3 keep the legacy 2-bit encoding
  localparam logic [3:0] COND_EQ     = 4'b0000;
  localparam logic [3:0] COND_NE     = 4'b0001;
  localparam logic [3:0] COND_GE     = 4'b0010;
  localparam logic [3:0] COND_LT     = 4'b0011;
  localparam logic [3:0] COND_GT     = 4'b0100;
  localparam logic [3:0] COND_LE     = 4'b0101;
  localparam logic [3:0] COND_GEU    = 4'b0110;
  localparam logic [3:0] COND_LTU    = 4'b0111;
  localparam logic [3:0] COND_ALWAYS = 4'b1000;
  localparam logic [3:0] COND_NEVER  = 4'b1001;

  // Width of the optional evaluation counters
  localparam int STAT_W = 16;

  // Two-operand sequencing states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WAIT_B = 1'b1
  } state_t;

endpackage

// File: rtl/con_compare.sv
// Combinational condition evaluator: a <cond> b over DATA_W bits, flags reserved codes.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result follows inputs.
module con_compare #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        cond,
  output logic              result,
  output logic              reserved
);
  import con_pkg::*;

  logic eq;
  logic lt_s;
  logic lt_u;

  // Three primitive relations; every code is derived from these
  always_comb begin
    eq   = (a == b);
    lt_s = ($signed(a) < $signed(b));
    lt_u = (a < b);
  end

  // Decode the condition code; reserved codes evaluate false and raise reserved
  always_comb begin
    result   = 1'b0;
    reserved = 1'b0;
    case (cond)
      COND_EQ:     result = eq;
      COND_NE:     result = !eq;
      COND_GE:     result = !lt_s;
      COND_LT:     result = lt_s;
      COND_GT:     result = !lt_s && !eq;
      COND_LE:     result = lt_s || eq;
      COND_GEU:    result = !lt_u;
      COND_LTU:    result = lt_u;
      COND_ALWAYS: result = 1'b1;
      COND_NEVER:  result = 1'b0;
      default:     reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/con_unit.sv
// Branch-condition unit: evaluates ir_cond on bus data (vs 0 or vs a latched operand) into one of NUM_FLAGS flags.
// Latency: flag, done and err become visible one cycle after the con_in edge; con_sel is combinational.
// Backpressure: none; a strobe is accepted every cycle, busy marks a pending second operand. Optional counters: CON_STATS_EN.
module con_unit
  import con_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_FLAGS = 4,
  parameter int SEL_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [DATA_W-1:0]    bus_data,
  input  logic [3:0]           ir_cond,
  input  logic [SEL_W-1:0]     ir_flag_sel,
  input  logic                 two_op,
  input  logic                 con_in,
  input  logic                 con_abort,
  output logic [NUM_FLAGS-1:0] con_out,
  output logic                 con_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef CON_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [STAT_W-1:0]    stat_eval,
  output logic [STAT_W-1:0]    stat_true
`endif
);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     op_a_q, op_a_d;
  logic [NUM_FLAGS-1:0]  flags_q, flags_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // FSM outputs
  logic                  eval_fire;
  logic                  latch_a;

  // Comparator operands and results
  logic [DATA_W-1:0]     cmp_x;
  logic [DATA_W-1:0]     cmp_y;
  logic                  cmp_result;
  logic                  cmp_reserved;
  logic                  sel_valid;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort beats a same-cycle strobe while waiting for operand B
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (con_in && two_op) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (con_abort || con_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: when to evaluate, when to capture operand A, and busy
  always_comb begin
    eval_fire = 1'b0;
    latch_a   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        eval_fire = con_in && !two_op;
        latch_a   = con_in && two_op;
      end
      ST_WAIT_B: begin
        busy      = 1'b1;
        eval_fire = con_in && !con_abort;
      end
      default: begin
        eval_fire = 1'b0;
      end
    endcase
  end

  // Operand steering: single-op compares bus vs 0, two-op compares latched A vs bus
  always_comb begin
    if (state_q == ST_WAIT_B) begin
      cmp_x = op_a_q;
      cmp_y = bus_data;
    end else begin
      cmp_x = bus_data;
      cmp_y = '0;
    end
  end

  con_compare #(
    .DATA_W (DATA_W)
  ) u_compare (
    .a        (cmp_x),
    .b        (cmp_y),
    .cond     (ir_cond),
    .result   (cmp_result),
    .reserved (cmp_reserved)
  );

  // Datapath next values: write only the selected flag, pulse done/err on each evaluation
  always_comb begin
    sel_valid = (int'(ir_flag_sel) < NUM_FLAGS);
    op_a_d    = op_a_q;
    flags_d   = flags_q;
    done_d    = eval_fire;
    err_d     = eval_fire && (cmp_reserved || !sel_valid);
    if (latch_a) begin
      op_a_d = bus_data;
    end
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (eval_fire && sel_valid && (ir_flag_sel == SEL_W'(i))) begin
        flags_d[i] = cmp_result;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_a_q  <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Read back the addressed flag; an out-of-range select reads as 0
  always_comb begin
    con_sel = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (ir_flag_sel == SEL_W'(i)) begin
        con_sel = flags_q[i];
      end
    end
  end

  assign con_out = flags_q;
  assign done    = done_q;
  assign err     = err_q;

`ifdef CON_STATS_EN
  logic [STAT_W-1:0] stat_eval_q, stat_eval_d;
  logic [STAT_W-1:0] stat_true_q, stat_true_d;

  // Saturating counters, counted at the evaluation edge; clear beats increment
  always_comb begin
    stat_eval_d = stat_eval_q;
    stat_true_d = stat_true_q;
    if (stat_clr) begin
      stat_eval_d = '0;
      stat_true_d = '0;
    end else if (eval_fire) begin
      if (stat_eval_q != {STAT_W{1'b1}}) begin
        stat_eval_d = stat_eval_q + STAT_W'(1);
      end
      if (cmp_result && (stat_true_q != {STAT_W{1'b1}})) begin
        stat_true_d = stat_true_q + STAT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stat_eval_q <= '0;
      stat_true_q <= '0;
    end else begin
      stat_eval_q <= stat_eval_d;
      stat_true_q <= stat_true_d;
    end
  end

  assign stat_eval = stat_eval_q;
  assign stat_true = stat_true_q;
`endif

endmodule
